// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch alignment buffer.
// Combinational definitions only; no latency and no backpressure.
package fetch_pkg;

    typedef logic [15:0] hw_t;

    // Low two bits of a 32-bit (non-compressed) RISC-V instruction
    localparam logic [1:0] RVC_QUAD_32 = 2'b11;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_SKIP = 1'b1
    } align_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

endpackage

// File: rtl/fetch_align_buf_if.sv
// Fetch-response and instruction-output handshake bundle for fetch_align_buf.
// slave = the buffer; master = fetch unit plus decode side (or a testbench).
interface fetch_align_buf_if;

    logic        flush;
    logic [31:0] flush_pc;

    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_data;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic        instr_is16;
    logic [31:0] instr_pc;

    modport slave (
        input  flush, flush_pc, ifu_rsp_valid, ifu_rsp_data, instr_ready,
        output ifu_rsp_ready, instr_valid, instr_data, instr_is16, instr_pc
    );

    modport master (
        output flush, flush_pc, ifu_rsp_valid, ifu_rsp_data, instr_ready,
        input  ifu_rsp_ready, instr_valid, instr_data, instr_is16, instr_pc
    );

endinterface

// File: rtl/align_hw_fifo.sv
// Circular halfword buffer: 0/1/2 halfwords written and 0/1/2 read per cycle.
// Latency: a write is visible on rd_hw0/rd_hw1 the following cycle.
// Backpressure: none internally; the caller must not overfill or overdrain.
module align_hw_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [1:0]    wr_cnt,
    input  hw_t           wr_hw0,
    input  hw_t           wr_hw1,
    input  logic [1:0]    rd_cnt,
    output hw_t           rd_hw0,
    output hw_t           rd_hw1,
    output logic [CW-1:0] count
);

    hw_t           mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointer advance modulo DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW+1:0] s;
        s = {2'b00, p} + {{PW{1'b0}}, n};
        if (s >= (PW+2)'(DEPTH))
            s = s - (PW+2)'(DEPTH);
        return s[PW-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= wrap_add(rd_ptr, rd_cnt);
            wr_ptr <= wrap_add(wr_ptr, wr_cnt);
            count  <= count + CW'(wr_cnt) - CW'(rd_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            if (wr_cnt != 2'd0)
                mem[wr_ptr] <= wr_hw0;
            if (wr_cnt == 2'd2)
                mem[wrap_add(wr_ptr, 2'd1)] <= wr_hw1;
        end
    end

    assign rd_hw0 = mem[rd_ptr];
    assign rd_hw1 = mem[wrap_add(rd_ptr, 2'd1)];

endmodule

// File: rtl/fetch_align_buf.sv
// Splits word-aligned fetch words into 16/32-bit instructions with PC; RVC via FETCH_ALIGN_RVC_EN.
// Latency: a word accepted in cycle N can be presented at the head in cycle N+1.
// Backpressure: ifu_rsp_ready only when two halfword slots are free (registered count, no pop-through).
module fetch_align_buf
    import fetch_pkg::*;
#(
    parameter int          HW_DEPTH = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fetch_align_buf_if.slave  bus
);

    localparam int CW = $clog2(HW_DEPTH + 1);

    align_state_t  state;
    align_state_t  state_n;
    logic [31:0]   head_pc;
    logic [CW-1:0] count;
    hw_t           rd_hw0;
    hw_t           rd_hw1;
    logic          head16;
    logic          push;
    logic          pop;
    logic          skip;
    logic [1:0]    wr_cnt;
    logic [1:0]    rd_cnt;
    logic          unused_flush_pc;

    assign skip = (state == S_SKIP);
    assign bus.ifu_rsp_ready = (count <= CW'(HW_DEPTH - 2));
    assign push = bus.ifu_rsp_valid & bus.ifu_rsp_ready & ~bus.flush;

`ifdef FETCH_ALIGN_RVC_EN
    // Gated on count so stale buffer contents never show as a compressed head
    assign head16 = (count != '0) && (rd_hw0[1:0] != RVC_QUAD_32);
    assign unused_flush_pc = bus.flush_pc[0];
`else
    assign head16 = 1'b0;
    assign unused_flush_pc = ^bus.flush_pc[1:0];
`endif

    assign bus.instr_valid = (head16 && count >= CW'(1)) || (count >= CW'(2));
    assign bus.instr_is16  = head16;
    assign bus.instr_pc    = head_pc;
    assign bus.instr_data  = !bus.instr_valid ? 32'h0 :
                             head16           ? {16'h0, rd_hw0} : {rd_hw1, rd_hw0};

    assign pop    = bus.instr_valid & bus.instr_ready & ~bus.flush;
    assign rd_cnt = !pop ? 2'd0 : (head16 ? 2'd1 : 2'd2);
    assign wr_cnt = !push ? 2'd0 : (skip ? 2'd1 : 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_RUN;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bus.flush) begin
`ifdef FETCH_ALIGN_RVC_EN
            state_n = bus.flush_pc[1] ? S_SKIP : S_RUN;
`else
            state_n = S_RUN;
`endif
        end else if (push && skip) begin
            state_n = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_pc <= RESET_PC;
        end else if (bus.flush) begin
`ifdef FETCH_ALIGN_RVC_EN
            head_pc <= {bus.flush_pc[31:1], 1'b0};
`else
            head_pc <= {bus.flush_pc[31:2], 2'b00};
`endif
        end else if (pop) begin
            head_pc <= head_pc + (head16 ? 32'd2 : 32'd4);
        end
    end

    align_hw_fifo #(
        .DEPTH (HW_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.flush),
        .wr_cnt (wr_cnt),
        .wr_hw0 (skip ? bus.ifu_rsp_data[31:16] : bus.ifu_rsp_data[15:0]),
        .wr_hw1 (bus.ifu_rsp_data[31:16]),
        .rd_cnt (rd_cnt),
        .rd_hw0 (rd_hw0),
        .rd_hw1 (rd_hw1),
        .count  (count)
    );

endmodule

// File: doc/fetch_align_buf.md
Name: fetch_align_buf

Overview:
- Sits between the instruction fetch response path and the RVC expander and decode.
- Accepts 32-bit, word-aligned fetch words and buffers them as halfwords.
- Extracts one instruction per cycle: 16-bit (bits[1:0]!=2'b11) or 32-bit, including 32-bit instructions that span two fetch words.
- Presents raw instruction bits, size flag and PC. The downstream rv16torv32 expander consumes instr_data[15:0] when instr_is16=1.

Parameters:
- HW_DEPTH, 4, halfword buffer capacity; even, >=4.
- RESET_PC, 32'h8000_0000, instr_pc value after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  redirect; clears buffer this cycle.
- flush_pc  input  32  new PC; bit[1] selects halfword start; bit[0] ignored.
- ifu_rsp_valid  input  1  fetch word valid.
- ifu_rsp_ready  output  1  buffer can accept a full word.
- ifu_rsp_data  input  32  fetch word; halfword0=[15:0], halfword1=[31:16].
- instr_valid  output  1  complete instruction at head.
- instr_ready  input  1  downstream accepts.
- instr_data  output  32  32-bit: {hw1,hw0}; 16-bit: {16'h0,hw0}.
- instr_is16  output  1  head instruction is compressed.
- instr_pc  output  32  PC of head instruction.

Behaviour:
- Storage: circular halfword FIFO with rd_ptr, wr_ptr and count (width $clog2(HW_DEPTH+1)), plus head_pc register.
- Reset (async): count=0, pointers=0, head_pc=RESET_PC, state=S_RUN. Outputs: instr_valid=0, instr_data=0, instr_is16=0, instr_pc=RESET_PC, ifu_rsp_ready=1.
- States:
  - S_RUN: normal operation.
  - S_SKIP: next accepted word discards hw0.
  - Flush with flush_pc[1]=1 -> S_SKIP; flush with flush_pc[1]=0 -> S_RUN.
  - In S_SKIP, a push writes only hw1 (count+1), then -> S_RUN.
- Push:
  - ifu_rsp_ready = (count <= HW_DEPTH-2), from registered count only; no pop-through.
  - Push when ifu_rsp_valid & ifu_rsp_ready & !flush. S_RUN adds 2 halfwords.
- Head decode:
  - head16 = (hw[rd_ptr][1:0] != 2'b11).
  - instr_valid = (count>=1 & head16) | (count>=2).
  - instr_is16 = head16.
  - All outputs are combinational from registers. instr_data = 0 when !instr_valid.
- Pop on instr_valid & instr_ready:
  - rd_ptr advances 1 (16-bit) or 2 (32-bit), modulo HW_DEPTH.
  - head_pc += 2 or 4, 32-bit wrap.
- Push and pop in the same cycle: count = count + pushed - popped.
- Latency: a word pushed in cycle N is visible at the head in cycle N+1.
- Spanning: a 32-bit head with count==1 holds instr_valid=0 until the next word arrives. No partial output.
- Flush has priority over push and pop in the same cycle:
  - count=0, pointers=0, head_pc={flush_pc[31:1],1'b0}.
  - instr_valid=0 the following cycle.
  - A response presented in the flush cycle is dropped.
- The fetch unit kills outstanding stale responses after a flush; this block does not tag them.
- Reset mid-operation returns everything to reset values immediately. No pending state survives.
- Instruction in flight is never split across a flush. Output is stable while instr_valid & !instr_ready & !flush.

Optional Feature:
- FETCH_ALIGN_RVC_EN defined: behaviour as above.
- Undefined:
  - Every instruction is treated as 32-bit; instr_is16 tied 0.
  - flush_pc[1] ignored; S_SKIP never entered.
  - head_pc always advances by 4.
  - instr_valid = (count>=2).

Decomposition:
- Shared package fetch_pkg: halfword typedef (logic[15:0]), RVC_QUAD_32 = 2'b11, align state enum {S_RUN, S_SKIP}, RESET_PC default constant.
- One sub-module, align_hw_fifo: halfword circular buffer with 2-wide write (1-wide in skip), 1/2-wide read, count. The top holds the FSM, head decode and PC.

Test Plan:
- Reset, push 32'h00A5_0513 -> next cycle instr_valid=1, is16=0, instr_data=32'h00A50513, instr_pc=32'h8000_0000; pop -> pc 32'h8000_0004.
- Push 32'h4505_0505 -> two outputs: 32'h0000_0505 at pc 32'h8000_0000, then 32'h0000_4505 at 32'h8000_0002, both is16=1.
- Push 32'h0513_4505 then 32'h1111_00A5:
  - 16-bit 4505 at +0.
  - instr_valid stays 0 until the second word arrives.
  - Then 32'h00A50513 at +2, then head hw 16'h1111 (is16=1) at +6.
- flush=1, flush_pc=32'h8000_0102, push 32'h4505_FFFF -> 16'h4505 at 32'h8000_0102; hw0 16'hFFFF discarded.
- instr_ready=0 with two words pushed -> ifu_rsp_ready=0 at count=4, outputs stable. A response presented with flush=1 is dropped: instr_valid=0 next cycle.
- Assert rst with count=3 -> instr_valid=0 and instr_pc=RESET_PC immediately (async), ifu_rsp_ready=1.
